// File: rtl/nna_reg_pkg.sv
// nna_reg_pkg: register map, bit indices, response codes and FSM state types for order_reg_slave
package nna_reg_pkg;
  localparam logic [4:0] REG_CTRL    = 5'h00;
  localparam logic [4:0] REG_STATUS  = 5'h04;
  localparam logic [4:0] REG_FEATURE = 5'h08;
  localparam logic [4:0] REG_WEIGHT  = 5'h0C;
  localparam logic [4:0] REG_OUTPUT  = 5'h10;
  localparam logic [4:0] REG_SHAPE   = 5'h14;
  localparam logic [4:0] REG_CHANNEL = 5'h18;
  localparam logic [4:0] REG_COUNT   = 5'h1C;
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  function automatic logic [31:0] merge_bytes(logic [31:0] old, logic [31:0] wd, logic [3:0] strb);
    for (int i = 0; i < 4; i++) merge_bytes[8*i +: 8] = strb[i] ? wd[8*i +: 8] : old[8*i +: 8];
  endfunction
endpackage

// File: rtl/axi_lite_wr_capture.sv
// axi_lite_wr_capture: AXI-Lite AW/W capture and W_IDLE/W_RESP FSM; ports: AW/W/B channels in, one-cycle wr_commit with addr/data/strb out, wr_err in selects bresp
module axi_lite_wr_capture
  import nna_reg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  wr_commit,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_strb,
  input  logic                  wr_err
);
  wr_state_t state, state_n;
  logic aw_held, w_held, aw_hs, w_hs;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W/8-1:0] strb_q;
  always_ff @(posedge clk)
    if (rst) state <= W_IDLE;
    else state <= state_n;
  always_comb
    state_n = state == W_IDLE ? (wr_commit ? W_RESP : W_IDLE) : (bready ? W_IDLE : W_RESP);
  always_comb begin
    awready   = state == W_IDLE && !aw_held;
    wready    = state == W_IDLE && !w_held;
    bvalid    = state == W_RESP;
    aw_hs     = awvalid && awready;
    w_hs      = wvalid && wready;
    wr_commit = state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
    wr_addr   = aw_held ? addr_q : awaddr;
    wr_data   = w_held ? data_q : wdata;
    wr_strb   = w_held ? strb_q : wstrb;
  end
  always_ff @(posedge clk)
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bresp   <= RESP_OKAY;
    end else if (wr_commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        addr_q  <= awaddr;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        data_q <= wdata;
        strb_q <= wstrb;
      end
    end
endmodule

// File: rtl/order_reg_slave.sv
// order_reg_slave: AXI-Lite task-order register file; ports: s00_axi_* slave, task_start/task_finish/busy/irq handshake, DDR base addresses and layer shape out
module order_reg_slave
  import nna_reg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  system_clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s00_axi_awaddr,
  input  logic [2:0]            s00_axi_awprot,
  input  logic                  s00_axi_awvalid,
  output logic                  s00_axi_awready,
  input  logic [DATA_W-1:0]     s00_axi_wdata,
  input  logic [DATA_W/8-1:0]   s00_axi_wstrb,
  input  logic                  s00_axi_wvalid,
  output logic                  s00_axi_wready,
  output logic [1:0]            s00_axi_bresp,
  output logic                  s00_axi_bvalid,
  input  logic                  s00_axi_bready,
  input  logic [ADDR_W-1:0]     s00_axi_araddr,
  input  logic [2:0]            s00_axi_arprot,
  input  logic                  s00_axi_arvalid,
  output logic                  s00_axi_arready,
  output logic [DATA_W-1:0]     s00_axi_rdata,
  output logic [1:0]            s00_axi_rresp,
  output logic                  s00_axi_rvalid,
  input  logic                  s00_axi_rready,
  output logic                  task_start,
  input  logic                  task_finish,
  output logic                  busy,
  output logic                  irq,
  output logic [DATA_W-1:0]     feature_addr,
  output logic [DATA_W-1:0]     weight_addr,
  output logic [DATA_W-1:0]     output_addr,
  output logic [15:0]           img_width,
  output logic [15:0]           img_height,
  output logic [15:0]           in_ch,
  output logic [15:0]           out_ch
);
  logic wr_commit, wr_err, wr_ok, w_unmapped, w_cfg, w_start_bit, start_go, finish, clr_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W/8-1:0] wr_strb;
  logic [4:0] wa, ra;
  logic irq_en, done;
  logic [DATA_W-1:0] shape_q, chan_q, task_count, rd_val;
  logic r_unmapped;
  rd_state_t rd_state, rd_state_n;
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_araddr[1:0], wr_addr[1:0]};
  axi_lite_wr_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr (
    .clk(system_clk),
    .rst(rst),
    .awaddr(s00_axi_awaddr),
    .awvalid(s00_axi_awvalid),
    .awready(s00_axi_awready),
    .wdata(s00_axi_wdata),
    .wstrb(s00_axi_wstrb),
    .wvalid(s00_axi_wvalid),
    .wready(s00_axi_wready),
    .bresp(s00_axi_bresp),
    .bvalid(s00_axi_bvalid),
    .bready(s00_axi_bready),
    .wr_commit(wr_commit),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_strb(wr_strb),
    .wr_err(wr_err)
  );
  // Error checks use pre-update busy, so a START racing task_finish is still rejected.
  always_comb begin
    wa          = {wr_addr[4:2], 2'b00};
    w_unmapped  = |wr_addr[ADDR_W-1:5];
    w_cfg       = wa >= REG_FEATURE && wa <= REG_CHANNEL;
    w_start_bit = wr_strb[0] && wr_data[CTRL_START];
    wr_err      = w_unmapped || wa == REG_COUNT || (busy && w_cfg) || (busy && wa == REG_CTRL && w_start_bit);
    wr_ok       = wr_commit && !wr_err;
    start_go    = wr_ok && wa == REG_CTRL && w_start_bit;
    clr_done    = wr_ok && wa == REG_STATUS && wr_strb[0] && wr_data[STAT_DONE];
    finish      = task_finish && busy;
  end
  always_ff @(posedge system_clk)
    if (rst) begin
      irq_en       <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      task_start   <= 1'b0;
      irq          <= 1'b0;
      feature_addr <= '0;
      weight_addr  <= '0;
      output_addr  <= '0;
      shape_q      <= '0;
      chan_q       <= '0;
      task_count   <= '0;
    end else begin
      if (wr_ok && wa == REG_CTRL && wr_strb[0]) irq_en <= wr_data[CTRL_IRQ_EN];
      if (wr_ok && wa == REG_FEATURE) feature_addr <= merge_bytes(feature_addr, wr_data, wr_strb);
      if (wr_ok && wa == REG_WEIGHT) weight_addr <= merge_bytes(weight_addr, wr_data, wr_strb);
      if (wr_ok && wa == REG_OUTPUT) output_addr <= merge_bytes(output_addr, wr_data, wr_strb);
      if (wr_ok && wa == REG_SHAPE) shape_q <= merge_bytes(shape_q, wr_data, wr_strb);
      if (wr_ok && wa == REG_CHANNEL) chan_q <= merge_bytes(chan_q, wr_data, wr_strb);
      if (finish) task_count <= task_count + 32'd1;
      task_start <= start_go;
      busy       <= start_go || (busy && !task_finish);
      done       <= finish || (done && !clr_done);
      irq        <= done && irq_en;
    end
  assign img_width  = shape_q[15:0];
  assign img_height = shape_q[31:16];
  assign in_ch      = chan_q[15:0];
  assign out_ch     = chan_q[31:16];
  always_comb begin
    ra         = {s00_axi_araddr[4:2], 2'b00};
    r_unmapped = |s00_axi_araddr[ADDR_W-1:5];
    rd_val     = '0;
    case (ra)
      REG_CTRL:    rd_val[CTRL_IRQ_EN] = irq_en;
      REG_STATUS:  rd_val[STAT_DONE:STAT_BUSY] = {done, busy};
      REG_FEATURE: rd_val = feature_addr;
      REG_WEIGHT:  rd_val = weight_addr;
      REG_OUTPUT:  rd_val = output_addr;
      REG_SHAPE:   rd_val = shape_q;
      REG_CHANNEL: rd_val = chan_q;
      default:     rd_val = task_count;
    endcase
    rd_val = r_unmapped ? '0 : rd_val;
  end
  always_ff @(posedge system_clk)
    if (rst) rd_state <= R_IDLE;
    else rd_state <= rd_state_n;
  always_comb
    rd_state_n = rd_state == R_IDLE ? (s00_axi_arvalid ? R_DATA : R_IDLE) : (s00_axi_rready ? R_IDLE : R_DATA);
  always_comb begin
    s00_axi_arready = rd_state == R_IDLE;
    s00_axi_rvalid  = rd_state == R_DATA;
  end
  always_ff @(posedge system_clk)
    if (rst) begin
      s00_axi_rdata <= '0;
      s00_axi_rresp <= RESP_OKAY;
    end else if (s00_axi_arvalid && s00_axi_arready) begin
      s00_axi_rdata <= rd_val;
      s00_axi_rresp <= r_unmapped ? RESP_SLVERR : RESP_OKAY;
    end
endmodule

// File: tb/tb_order_reg_slave.sv
// tb_order_reg_slave: scoreboard bench for order_reg_slave with directed AXI-Lite transactions
module tb_order_reg_slave;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic arvalid = 1'b0, arready, rvalid, rready = 1'b0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic task_start, task_finish = 1'b0, busy, irq;
  logic [31:0] feature_addr, weight_addr, output_addr;
  logic [15:0] img_width, img_height, in_ch, out_ch;
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  int ncmp = 0, nerr = 0, nb = 0, nb_exp = 0, starts = 0;
  always #5 clk = ~clk;
  order_reg_slave dut (
    .system_clk(clk), .rst(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .task_start(task_start), .task_finish(task_finish), .busy(busy), .irq(irq),
    .feature_addr(feature_addr), .weight_addr(weight_addr), .output_addr(output_addr),
    .img_width(img_width), .img_height(img_height), .in_ch(in_ch), .out_ch(out_ch)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic bad(input string nm);
    ncmp++;
    nerr++;
    $display("FAIL %s", nm);
  endtask
  always @(negedge clk) begin
    if (bvalid && bready) begin
      nb++;
      if (bq.size() == 0) bad("unexpected_bresp");
      else chk("bresp", {30'b0, bresp}, {30'b0, bq.pop_front()});
    end
    if (rvalid && rready) begin
      if (rq.size() == 0) bad("unexpected_rdata");
      else begin
        logic [33:0] e;
        e = rq.pop_front();
        chk("rdata", rdata, e[33:2]);
        chk("rresp", {30'b0, rresp}, {30'b0, e[1:0]});
      end
    end
    if (task_start) begin
      starts++;
      chk("start_with_bvalid", {31'b0, bvalid}, 32'd1);
    end
  end
  task automatic wait_b();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bvalid && bready;
      @(posedge clk);
      #1;
    end
    if (!ok) bad("bvalid_timeout");
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    logic aw_ok, w_ok;
    bq.push_back(r);
    nb_exp++;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      @(negedge clk);
      aw_ok = awvalid && awready;
      w_ok = wvalid && wready;
      @(posedge clk);
      #1;
      if (aw_ok) awvalid = 1'b0;
      if (w_ok) wvalid = 1'b0;
    end
    if (awvalid || wvalid) bad("aw_w_timeout");
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b();
  endtask
  task automatic wr_fin(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    bq.push_back(r);
    nb_exp++;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; task_finish = 1'b1;
    @(negedge clk);
    chk("fin_awready", {31'b0, awready && wready}, 32'd1);
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0; task_finish = 1'b0;
    wait_b();
  endtask
  task automatic rd(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
    logic ok;
    rq.push_back({d, r});
    araddr = a; arvalid = 1'b1; rready = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = arready;
      @(posedge clk);
      #1;
    end
    arvalid = 1'b0;
    if (!ok) bad("arready_timeout");
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = rvalid;
      @(posedge clk);
      #1;
    end
    if (!ok) bad("rvalid_timeout");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", {29'b0, awready, wready, arready}, 32'h7);
    chk("rst_valid", {30'b0, bvalid, rvalid}, 32'h0);
    chk("rst_resp", {28'b0, bresp, rresp}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ctl", {29'b0, task_start, busy, irq}, 32'h0);
    chk("rst_feature", feature_addr, 32'h0);
    wr(8'h08, 32'h1000_0000, 4'hF, 2'b00);
    wr(8'h14, 32'h0100_0200, 4'hF, 2'b00);
    rd(8'h08, 32'h1000_0000, 2'b00);
    rd(8'h14, 32'h0100_0200, 2'b00);
    chk("feature_addr", feature_addr, 32'h1000_0000);
    chk("img_width", {16'b0, img_width}, 32'h0200);
    chk("img_height", {16'b0, img_height}, 32'h0100);
    bq.push_back(2'b00);
    nb_exp++;
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    chk("w_first_wready", {31'b0, wready}, 32'd1);
    @(posedge clk);
    #1 wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("w_held_wready", {31'b0, wready}, 32'd0);
      @(posedge clk);
      #1;
    end
    awaddr = 8'h10; awvalid = 1'b1;
    @(negedge clk);
    chk("late_awready", {31'b0, awready}, 32'd1);
    @(posedge clk);
    #1 awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("resp_hold", {29'b0, bvalid, awready, wready}, 32'h4);
      @(posedge clk);
      #1;
    end
    bready = 1'b1;
    wait_b();
    chk("output_addr", output_addr, 32'h1234_5678);
    wr(8'h00, 32'h3, 4'hF, 2'b00);
    chk("start_count", starts, 1);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    wr(8'h0C, 32'hDEAD_BEEF, 4'hF, 2'b10);
    chk("weight_unchanged", weight_addr, 32'h0);
    wr(8'h00, 32'h1, 4'hF, 2'b10);
    chk("no_second_start", starts, 1);
    task_finish = 1'b1;
    @(posedge clk);
    #1 task_finish = 1'b0;
    chk("busy_cleared", {31'b0, busy}, 32'd0);
    chk("irq_latency", {31'b0, irq}, 32'd0);
    @(posedge clk);
    #1;
    chk("irq_set", {31'b0, irq}, 32'd1);
    rd(8'h04, 32'h2, 2'b00);
    rd(8'h1C, 32'h1, 2'b00);
    rd(8'h00, 32'h2, 2'b00);
    wr(8'h04, 32'h2, 4'hF, 2'b00);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    wr(8'h00, 32'h1, 4'h1, 2'b00);
    chk("start_count2", starts, 2);
    wr_fin(8'h04, 32'h2, 4'hF, 2'b00);
    chk("busy_after_fin", {31'b0, busy}, 32'd0);
    rd(8'h04, 32'h2, 2'b00);
    rd(8'h1C, 32'h2, 2'b00);
    wr(8'h00, 32'h1, 4'h1, 2'b00);
    chk("start_count3", starts, 3);
    wr_fin(8'h00, 32'h1, 4'h1, 2'b10);
    chk("start_race", starts, 3);
    chk("busy_race", {31'b0, busy}, 32'd0);
    rd(8'h24, 32'h0, 2'b10);
    wr(8'h1C, 32'h5, 4'hF, 2'b10);
    rd(8'h1C, 32'h3, 2'b00);
    wr(8'h18, 32'hAABB_CCDD, 4'b0101, 2'b00);
    chk("in_ch", {16'b0, in_ch}, 32'h00DD);
    chk("out_ch", {16'b0, out_ch}, 32'h00BB);
    wr(8'h18, 32'h1122_3344, 4'b1010, 2'b00);
    rd(8'h18, 32'h11BB_33DD, 2'b00);
    awaddr = 8'h08; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst_bvalid", {31'b0, bvalid}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_drops_bvalid", {31'b0, bvalid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst2_feature", feature_addr, 32'h0);
    chk("rst2_output", output_addr, 32'h0);
    chk("rst2_shape", {img_height, img_width}, 32'h0);
    chk("rst2_ctl", {28'b0, busy, irq, awready, wready}, 32'h3);
    rd(8'h1C, 32'h0, 2'b00);
    rd(8'h18, 32'h0, 2'b00);
    rd(8'h00, 32'h0, 2'b00);
    repeat (2) @(posedge clk);
    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("b_handshakes", nb, nb_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
